// File: rtl/traffic_checker.sv
// traffic_checker: AXI Stream sink and protocol checker for the traffic
// generator. Drives a periodic on/off TREADY pattern, consumes a configured
// number of packets, and checks length, TLAST placement and TKEEP shape.
// Optional build macro TRAFFIC_CHECKER_DATA_CHECK_EN adds a TDATA check
// (flit index in [15:0], packet index in [31:16]) reported as error code 5.
module traffic_checker #(
  parameter int WIDTH = 256
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [15:0]        num_packets,
  input  logic [15:0]        num_flits,
  input  logic [7:0]         last_flit_bytes,
  input  logic [15:0]        M,
  input  logic [15:0]        N,
  input  logic [WIDTH-1:0]   TDATA,
  input  logic [WIDTH/8-1:0] TKEEP,
  input  logic               TVALID,
  output logic               TREADY,
  input  logic               TLAST,
  output logic               busy,
  output logic               done,
  output logic [15:0]        pkt_count,
  output logic               err,
  output logic [2:0]         err_code
);

  localparam int KW = WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [15:0]   numPackets_q, numPackets_d;
  logic [15:0]   numFlits_q, numFlits_d;
  logic [KW-1:0] keepLast_q, keepLast_d;
  logic [15:0]   onCycles_q, onCycles_d;
  logic [15:0]   offCycles_q, offCycles_d;
  logic [15:0]   phaseCnt_q, phaseCnt_d;
  logic          ready_q, ready_d;
  logic [15:0]   flitCnt_q, flitCnt_d;
  logic [15:0]   pktCount_q, pktCount_d;
  logic          err_q, err_d;
  logic [2:0]    errCode_q, errCode_d;

  logic [KW-1:0] startKeep;
  logic          accept;
  logic          lastExpected;
  logic          keepBad;
  logic          dataErr;
  logic [2:0]    beatCode;
  logic [15:0]   pktNext;
  logic          unusedData;

  assign unusedData = ^TDATA;

`ifdef TRAFFIC_CHECKER_DATA_CHECK_EN
  assign dataErr = (TDATA[15:0] != flitCnt_q) || (TDATA[31:16] != pktCount_q);
`else
  assign dataErr = 1'b0;
`endif

  // Expected last-beat TKEEP built from the live config inputs, latched on start
  always_comb begin
    startKeep = '1;
    if (last_flit_bytes != 8'd0 && int'(last_flit_bytes) <= KW) begin
      for (int i = 0; i < KW; i++) begin
        startKeep[i] = (i < int'(last_flit_bytes));
      end
    end
  end

  assign accept       = (state_q == RUN) && TVALID && ready_q;
  assign lastExpected = (flitCnt_q >= (numFlits_q - 16'd1));
  assign keepBad      = TLAST ? (TKEEP != keepLast_q) : (TKEEP != {KW{1'b1}});
  assign pktNext      = pktCount_q + 16'd1;

  // Per-beat error classification; the lowest code wins when several apply
  always_comb begin
    beatCode = 3'd0;
    if (TLAST && !lastExpected) begin
      beatCode = 3'd1;
    end else if (!TLAST && lastExpected) begin
      beatCode = 3'd2;
    end else if (keepBad) begin
      beatCode = 3'd3;
    end else if (dataErr) begin
      beatCode = 3'd5;
    end
  end

  // Next-state logic: run control, backpressure phase and beat bookkeeping
  always_comb begin
    state_d      = state_q;
    numPackets_d = numPackets_q;
    numFlits_d   = numFlits_q;
    keepLast_d   = keepLast_q;
    onCycles_d   = onCycles_q;
    offCycles_d  = offCycles_q;
    phaseCnt_d   = phaseCnt_q;
    ready_d      = ready_q;
    flitCnt_d    = flitCnt_q;
    pktCount_d   = pktCount_q;
    err_d        = err_q;
    errCode_d    = errCode_q;

    case (state_q)
      IDLE, DONE: begin
        ready_d = 1'b0;
        if (start) begin
          numPackets_d = num_packets;
          numFlits_d   = (num_flits == 16'd0) ? 16'd1 : num_flits;
          keepLast_d   = startKeep;
          onCycles_d   = (M == 16'd0) ? 16'd1 : M;
          offCycles_d  = N;
          phaseCnt_d   = 16'd0;
          flitCnt_d    = 16'd0;
          pktCount_d   = 16'd0;
          err_d        = 1'b0;
          errCode_d    = 3'd0;
          if (num_packets == 16'd0) begin
            state_d = DONE;
            ready_d = 1'b0;
          end else begin
            state_d = RUN;
            ready_d = 1'b1;
          end
        end
      end

      RUN: begin
        if (offCycles_q == 16'd0) begin
          ready_d    = 1'b1;
          phaseCnt_d = 16'd0;
        end else if (ready_q) begin
          if (phaseCnt_q == onCycles_q - 16'd1) begin
            ready_d    = 1'b0;
            phaseCnt_d = 16'd0;
          end else begin
            phaseCnt_d = phaseCnt_q + 16'd1;
          end
        end else begin
          if (phaseCnt_q == offCycles_q - 16'd1) begin
            ready_d    = 1'b1;
            phaseCnt_d = 16'd0;
          end else begin
            phaseCnt_d = phaseCnt_q + 16'd1;
          end
        end

        if (accept) begin
          if (!err_q && beatCode != 3'd0) begin
            err_d     = 1'b1;
            errCode_d = beatCode;
          end
          if (TLAST) begin
            flitCnt_d  = 16'd0;
            pktCount_d = pktNext;
            if (pktNext == numPackets_q) begin
              state_d = DONE;
              ready_d = 1'b0;
            end
          end else if (flitCnt_q != 16'hFFFF) begin
            flitCnt_d = flitCnt_q + 16'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b0;
      end
    endcase
  end

  // State and status registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      numPackets_q <= 16'd0;
      numFlits_q   <= 16'd1;
      keepLast_q   <= '1;
      onCycles_q   <= 16'd1;
      offCycles_q  <= 16'd0;
      phaseCnt_q   <= 16'd0;
      ready_q      <= 1'b0;
      flitCnt_q    <= 16'd0;
      pktCount_q   <= 16'd0;
      err_q        <= 1'b0;
      errCode_q    <= 3'd0;
    end else begin
      state_q      <= state_d;
      numPackets_q <= numPackets_d;
      numFlits_q   <= numFlits_d;
      keepLast_q   <= keepLast_d;
      onCycles_q   <= onCycles_d;
      offCycles_q  <= offCycles_d;
      phaseCnt_q   <= phaseCnt_d;
      ready_q      <= ready_d;
      flitCnt_q    <= flitCnt_d;
      pktCount_q   <= pktCount_d;
      err_q        <= err_d;
      errCode_q    <= errCode_d;
    end
  end

  assign TREADY    = ready_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign pkt_count = pktCount_q;
  assign err       = err_q;
  assign err_code  = errCode_q;

endmodule

// File: tb/tb_traffic_checker.sv
// tb_traffic_checker: directed bench for traffic_checker. Drives hand-built
// packets, waits on TREADY where backpressure applies, and compares status
// outputs against hand-computed values.
module tb_traffic_checker;

  localparam int WIDTH = 256;
  localparam int KW    = WIDTH / 8;
  localparam logic [KW-1:0] FULL = '1;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [15:0]      num_packets;
  logic [15:0]      num_flits;
  logic [7:0]       last_flit_bytes;
  logic [15:0]      M;
  logic [15:0]      N;
  logic [WIDTH-1:0] TDATA;
  logic [KW-1:0]    TKEEP;
  logic             TVALID;
  logic             TREADY;
  logic             TLAST;
  logic             busy;
  logic             done;
  logic [15:0]      pkt_count;
  logic             err;
  logic [2:0]       err_code;

  int compared    = 0;
  int mismatched  = 0;
  int readyHigh   = 0;
  int stallCycles = 0;
  int readyBase;

  traffic_checker #(.WIDTH(WIDTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .num_packets    (num_packets),
    .num_flits      (num_flits),
    .last_flit_bytes(last_flit_bytes),
    .M              (M),
    .N              (N),
    .TDATA          (TDATA),
    .TKEEP          (TKEEP),
    .TVALID         (TVALID),
    .TREADY         (TREADY),
    .TLAST          (TLAST),
    .busy           (busy),
    .done           (done),
    .pkt_count      (pkt_count),
    .err            (err),
    .err_code       (err_code)
  );

  // Free-running clock, 10 time units per cycle
  always #5 clk = ~clk;

  // Counts rising edges at which TREADY was high
  always @(posedge clk) begin
    if (TREADY === 1'b1) readyHigh <= readyHigh + 1;
  end

  // Hard stop in case the stimulus itself gets stuck
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] pkt, input logic [15:0] flit,
                               input logic [KW-1:0] keep, input logic last);
    int waits;
    TDATA         = '0;
    TDATA[15:0]   = flit;
    TDATA[31:16]  = pkt;
    TKEEP         = keep;
    TLAST         = last;
    TVALID        = 1'b1;
    waits = 0;
    while (TREADY !== 1'b1 && waits < 40) begin
      tick();
      waits++;
    end
    if (waits == 40) begin
      compared++;
      mismatched++;
      $error("[TB] FAIL beatTimeout: observed=TREADY low required=TREADY high");
    end else begin
      tick();
    end
    stallCycles += waits;
    TVALID = 1'b0;
    TLAST  = 1'b0;
  endtask

  task automatic startRun(input logic [15:0] np, input logic [15:0] nf,
                          input logic [7:0] lb, input logic [15:0] m,
                          input logic [15:0] n);
    num_packets     = np;
    num_flits       = nf;
    last_flit_bytes = lb;
    M               = m;
    N               = n;
    start           = 1'b1;
    tick();
    start           = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; TVALID = 1'b0; TLAST = 1'b0;
    TDATA = '0; TKEEP = '0;
    num_packets = 16'd0; num_flits = 16'd0; last_flit_bytes = 8'd0;
    M = 16'd0; N = 16'd0;
    tick();
    tick();
    checkOutput("rstTready", TREADY, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstDone", done, 0);
    checkOutput("rstPkt", pkt_count, 0);
    checkOutput("rstErr", err, 0);
    checkOutput("rstCode", err_code, 0);
    rst = 1'b0;
    tick();

    // Zero packets goes straight to DONE
    startRun(16'd0, 16'd4, 8'd0, 16'd1, 16'd0);
    checkOutput("zeroDone", done, 1);
    checkOutput("zeroBusy", busy, 0);
    checkOutput("zeroTready", TREADY, 0);

    // Clean run: 3 packets of 4 flits, no backpressure
    readyBase = readyHigh;
    startRun(16'd3, 16'd4, 8'd0, 16'd1, 16'd0);
    checkOutput("cleanStartBusy", busy, 1);
    checkOutput("cleanStartTready", TREADY, 1);
    checkOutput("cleanStartDone", done, 0);
    for (int p = 0; p < 3; p++) begin
      for (int f = 0; f < 4; f++) begin
        applyStimulus(16'(p), 16'(f), FULL, (f == 3));
      end
      if (p == 0) checkOutput("cleanPkt1", pkt_count, 1);
    end
    checkOutput("cleanDone", done, 1);
    checkOutput("cleanBusy", busy, 0);
    checkOutput("cleanTready", TREADY, 0);
    checkOutput("cleanPkt", pkt_count, 3);
    checkOutput("cleanErr", err, 0);
    checkOutput("cleanReadyCycles", readyHigh - readyBase, 12);

    // Backpressure: M=2, N=3, 2 packets of 2 flits
    stallCycles = 0;
    readyBase = readyHigh;
    startRun(16'd2, 16'd2, 8'd0, 16'd2, 16'd3);
    applyStimulus(16'd0, 16'd0, FULL, 1'b0);
    applyStimulus(16'd0, 16'd1, FULL, 1'b1);
    checkOutput("bpOffPhase", TREADY, 0);
    checkOutput("bpPkt1", pkt_count, 1);
    applyStimulus(16'd1, 16'd0, FULL, 1'b0);
    applyStimulus(16'd1, 16'd1, FULL, 1'b1);
    checkOutput("bpStalls", stallCycles, 3);
    checkOutput("bpReadyCycles", readyHigh - readyBase, 4);
    checkOutput("bpDone", done, 1);
    checkOutput("bpPkt", pkt_count, 2);
    checkOutput("bpErr", err, 0);

    // Early TLAST on the 2nd beat, then a correct packet
    startRun(16'd2, 16'd4, 8'd0, 16'd1, 16'd0);
    applyStimulus(16'd0, 16'd0, FULL, 1'b0);
    applyStimulus(16'd0, 16'd1, FULL, 1'b1);
    checkOutput("earlyErr", err, 1);
    checkOutput("earlyCode", err_code, 1);
    checkOutput("earlyPkt", pkt_count, 1);
    for (int f = 0; f < 4; f++) begin
      applyStimulus(16'd1, 16'(f), FULL, (f == 3));
    end
    checkOutput("earlyDone", done, 1);
    checkOutput("earlyPkt2", pkt_count, 2);
    checkOutput("earlyCodeHeld", err_code, 1);

    // Missing TLAST with num_flits=0 (treated as 1) and M=0 (treated as 1)
    startRun(16'd1, 16'd0, 8'd0, 16'd0, 16'd0);
    applyStimulus(16'd0, 16'd0, FULL, 1'b0);
    checkOutput("missErr", err, 1);
    checkOutput("missCode", err_code, 2);
    checkOutput("missBusy", busy, 1);
    applyStimulus(16'd0, 16'd1, FULL, 1'b1);
    checkOutput("missDone", done, 1);
    checkOutput("missPkt", pkt_count, 1);

    // Bad last-beat keep, then a missing TLAST that must not override it
    startRun(16'd2, 16'd2, 8'd5, 16'd1, 16'd0);
    applyStimulus(16'd0, 16'd0, FULL, 1'b0);
    applyStimulus(16'd0, 16'd1, KW'(32'h3F), 1'b1);
    checkOutput("keepErr", err, 1);
    checkOutput("keepCode", err_code, 3);
    applyStimulus(16'd1, 16'd0, FULL, 1'b0);
    applyStimulus(16'd1, 16'd1, FULL, 1'b0);
    checkOutput("keepCodeHeld", err_code, 3);
    checkOutput("keepBusy", busy, 1);
    applyStimulus(16'd1, 16'd2, KW'(32'h1F), 1'b1);
    checkOutput("keepDone", done, 1);
    checkOutput("keepPkt", pkt_count, 2);

    // Reset mid-packet overrides a simultaneous start
    startRun(16'd2, 16'd4, 8'd0, 16'd1, 16'd0);
    applyStimulus(16'd0, 16'd0, '0, 1'b0);
    checkOutput("midErrBefore", err_code, 3);
    applyStimulus(16'd0, 16'd1, FULL, 1'b0);
    rst = 1'b1;
    start = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b0;
    checkOutput("midTready", TREADY, 0);
    checkOutput("midBusy", busy, 0);
    checkOutput("midDone", done, 0);
    checkOutput("midPkt", pkt_count, 0);
    checkOutput("midErr", err, 0);
    checkOutput("midCode", err_code, 0);
    tick();
    checkOutput("midStillIdle", busy, 0);
    startRun(16'd1, 16'd2, 8'd0, 16'd1, 16'd0);
    applyStimulus(16'd0, 16'd0, FULL, 1'b0);
    applyStimulus(16'd0, 16'd1, FULL, 1'b1);
    checkOutput("postRstDone", done, 1);
    checkOutput("postRstPkt", pkt_count, 1);
    checkOutput("postRstErr", err, 0);

    // Data corruption on beat 1; last_flit_bytes above the bus width means full keep
    startRun(16'd1, 16'd2, 8'd40, 16'd1, 16'd0);
    applyStimulus(16'd0, 16'd0, FULL, 1'b0);
    applyStimulus(16'd0, 16'hBEEF, FULL, 1'b1);
    checkOutput("dataDone", done, 1);
`ifdef TRAFFIC_CHECKER_DATA_CHECK_EN
    checkOutput("dataErr", err, 1);
    checkOutput("dataCode", err_code, 5);
`else
    checkOutput("dataErr", err, 0);
    checkOutput("dataCode", err_code, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
